// File: rtl/updn_counter_param.sv
// updn_counter_param: loadable up/down counter with wrap or saturate at MAX_VAL, ovf/unf pulses and limit flags.
// Define COUNTER_SVA_EN to embed the concurrent assertions.
module updn_counter_param #(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = (1 << WIDTH) - 1,
  parameter int STEP     = 1,
  parameter bit SATURATE = 1'b0,
  parameter int RST_VAL  = 0
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             ld_cnt_,
  input  logic             count_enb,
  input  logic             updn_cnt,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             at_max,
  output logic             at_min,
  output logic             ovf,
  output logic             unf
);
  localparam logic [WIDTH:0]   max_x  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   step_x = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] max_v  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] step_v = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] mod_v  = WIDTH'(MAX_VAL + 1);
  localparam logic [WIDTH-1:0] rst_v  = WIDTH'(RST_VAL);
  logic [WIDTH:0]   cur, sum;
  logic [WIDTH-1:0] up_wrap, dn_wrap, up_nxt, dn_nxt, ld_nxt;
  logic             up_over, dn_under;
  // Wrapped results always fit WIDTH bits, so modulo-2**WIDTH arithmetic is exact here.
  always_comb begin
    cur      = {1'b0, data_out};
    sum      = cur + step_x;
    up_over  = sum > max_x;
    dn_under = cur < step_x;
    up_wrap  = sum[WIDTH-1:0] - mod_v;
    dn_wrap  = data_out + mod_v - step_v;
    up_nxt   = !up_over ? sum[WIDTH-1:0] : SATURATE ? max_v : up_wrap;
    dn_nxt   = !dn_under ? data_out - step_v : SATURATE ? '0 : dn_wrap;
    ld_nxt   = {1'b0, data_in} > max_x ? max_v : data_in;
  end
  assign at_max = data_out == max_v;
  assign at_min = data_out == '0;
  always_ff @(posedge clk) begin
    if (!rst_) begin
      data_out <= rst_v;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else if (!ld_cnt_) begin
      data_out <= ld_nxt;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else if (count_enb) begin
      data_out <= updn_cnt ? up_nxt : dn_nxt;
      ovf      <= updn_cnt && up_over;
      unf      <= !updn_cnt && dn_under;
    end else begin
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end
  end
`ifdef COUNTER_SVA_EN
  function automatic int exp_up(input int v);
    return v + STEP <= MAX_VAL ? v + STEP : SATURATE ? MAX_VAL : v + STEP - MAX_VAL - 1;
  endfunction
  function automatic int exp_dn(input int v);
    return v >= STEP ? v - STEP : SATURATE ? 0 : v + MAX_VAL + 1 - STEP;
  endfunction
  a_reset: assert property (@(posedge clk) !rst_ |=> data_out == rst_v && !ovf && !unf)
    else $error("reset check failed t=%0t data_out=%0d", $time, data_out);
  a_load: assert property (@(posedge clk) disable iff (!rst_)
    !ld_cnt_ |=> data_out == ($past(data_in) > max_v ? max_v : $past(data_in)))
    else $error("load check failed t=%0t data_out=%0d", $time, data_out);
  a_hold: assert property (@(posedge clk) disable iff (!rst_)
    ld_cnt_ && !count_enb |=> $stable(data_out))
    else $error("hold check failed t=%0t data_out=%0d", $time, data_out);
  a_up: assert property (@(posedge clk) disable iff (!rst_)
    ld_cnt_ && count_enb && updn_cnt |=>
      int'(data_out) == exp_up(int'($past(data_out))) && ovf == (int'($past(data_out)) + STEP > MAX_VAL))
    else $error("count up check failed t=%0t data_out=%0d", $time, data_out);
  a_dn: assert property (@(posedge clk) disable iff (!rst_)
    ld_cnt_ && count_enb && !updn_cnt |=>
      int'(data_out) == exp_dn(int'($past(data_out))) && unf == (int'($past(data_out)) < STEP))
    else $error("count down check failed t=%0t data_out=%0d", $time, data_out);
  a_range: assert property (@(posedge clk) disable iff (!rst_) data_out <= max_v)
    else $error("range check failed t=%0t data_out=%0d", $time, data_out);
  a_mutex: assert property (@(posedge clk) disable iff (!rst_) !(ovf && unf))
    else $error("mutex check failed t=%0t data_out=%0d", $time, data_out);
`endif
endmodule

// File: tb/tb_updn_counter_param.sv
// tb_updn_counter_param: three counter configurations driven together, checked by a queue scoreboard.
module tb_updn_counter_param;
  typedef struct { int idx; int val; bit o; bit u; } exp_t;
  logic       clk, rst_, ld_cnt_, count_enb, updn_cnt;
  logic [7:0] data_in, dout_w, dout_s;
  logic [3:0] dout_d;
  logic [2:0] ovf, unf, amax, amin;
  int         mx[3]  = '{99, 99, 15};
  int         st[3]  = '{3, 4, 1};
  bit         sat[3] = '{1'b0, 1'b1, 1'b0};
  int         rv[3]  = '{0, 5, 0};
  int         cnt[3];
  exp_t       q[$];
  int         errors = 0, checks = 0;

  updn_counter_param #(.WIDTH(8), .MAX_VAL(99), .STEP(3), .SATURATE(1'b0), .RST_VAL(0)) u_wrap (
    .clk(clk), .rst_(rst_), .ld_cnt_(ld_cnt_), .count_enb(count_enb), .updn_cnt(updn_cnt),
    .data_in(data_in), .data_out(dout_w), .at_max(amax[0]), .at_min(amin[0]), .ovf(ovf[0]), .unf(unf[0]));
  updn_counter_param #(.WIDTH(8), .MAX_VAL(99), .STEP(4), .SATURATE(1'b1), .RST_VAL(5)) u_sat (
    .clk(clk), .rst_(rst_), .ld_cnt_(ld_cnt_), .count_enb(count_enb), .updn_cnt(updn_cnt),
    .data_in(data_in), .data_out(dout_s), .at_max(amax[1]), .at_min(amin[1]), .ovf(ovf[1]), .unf(unf[1]));
  updn_counter_param #(.WIDTH(4)) u_def (
    .clk(clk), .rst_(rst_), .ld_cnt_(ld_cnt_), .count_enb(count_enb), .updn_cnt(updn_cnt),
    .data_in(data_in[3:0]), .data_out(dout_d), .at_max(amax[2]), .at_min(amin[2]), .ovf(ovf[2]), .unf(unf[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour straight from the counting rules, in plain integers.
  function automatic void model(input int i, input bit r, l, e, u, input int d,
                                output int nx, output bit o, output bit un);
    o = 1'b0;
    un = 1'b0;
    if (!r) nx = rv[i];
    else if (!l) nx = d > mx[i] ? mx[i] : d;
    else if (e && u) begin
      o = cnt[i] + st[i] > mx[i];
      nx = !o ? cnt[i] + st[i] : sat[i] ? mx[i] : (cnt[i] + st[i]) % (mx[i] + 1);
    end else if (e) begin
      un = cnt[i] < st[i];
      nx = !un ? cnt[i] - st[i] : sat[i] ? 0 : cnt[i] + mx[i] + 1 - st[i];
    end else nx = cnt[i];
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst=%0d got=%0d want=%0d at %0t", name, idx, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, l, e, u, input int d);
    int nx, di;
    bit o, un;
    rst_ = r; ld_cnt_ = l; count_enb = e; updn_cnt = u; data_in = 8'(d);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      di = i == 2 ? (d & 15) : (d & 255);
      model(i, r, l, e, u, di, nx, o, un);
      cnt[i] = nx;
      q.push_back('{i, nx, o, un});
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    int act;
    while (q.size() > 0) begin
      e = q.pop_front();
      act = e.idx == 0 ? int'(dout_w) : e.idx == 1 ? int'(dout_s) : int'(dout_d);
      chk("data_out", e.idx, act, e.val);
      chk("flags{ovf,unf,at_max,at_min}", e.idx,
          int'({ovf[e.idx], unf[e.idx], amax[e.idx], amin[e.idx]}),
          int'({e.o, e.u, e.val == mx[e.idx], e.val == 0}));
    end
  end

  initial begin
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(1, 0, 0, 0, 150);
    cyc(1, 0, 0, 0, 42);
    cyc(1, 0, 0, 0, 98);
    cyc(1, 1, 1, 1, 0);
    cyc(1, 1, 1, 1, 0);
    cyc(1, 0, 0, 0, 2);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 1, 1, 7);
    cyc(0, 0, 1, 1, 9);
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) cyc(1, 1, 1, 1, 0);
    cyc(1, 0, 0, 0, 99);
    for (int k = 0; k < 3; k++) cyc(1, 1, 1, 1, 0);
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 31) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
          1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard drained", 0, q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
